// File: rtl/jtag_az_monitor.sv
// PHI_AZ waveform monitor: measures high/low phase widths on TCK and checks them against NHIGH/NLOW.
// Optional JTAG_AZ_MON_STUCK_EN: flag and abort a period whose phase counter saturates.
module jtag_az_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        TCK,
  input  logic        RESET,
  input  logic        PHI_AZ_IN,
  input  logic        ARM,
  input  logic        CLEAR,
  input  logic [7:0]  NHIGH,
  input  logic [13:0] NLOW,
  input  logic [3:0]  TOL,
  output logic [7:0]  MEAS_HIGH,
  output logic [13:0] MEAS_LOW,
  output logic        MEAS_VALID,
  output logic [15:0] PERIOD_COUNT,
  output logic        ERR_HIGH,
  output logic        ERR_LOW,
  output logic        LOCKED,
  output logic        STUCK
);

  typedef enum logic [1:0] {StIdle, StWaitRise, StMeasHi, StMeasLo} state_e;

  localparam logic [13:0] CntMax = 14'h3fff;

  function automatic logic [14:0] abs_diff(input logic [14:0] a, input logic [14:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [13:0]            cnt_q, cnt_d;
  logic [7:0]             meas_high_q, meas_high_d;
  logic [13:0]            meas_low_q, meas_low_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [15:0]            period_q, period_d;
  logic                   err_high_q, err_high_d;
  logic                   err_low_q, err_low_d;
  logic                   stuck_q, stuck_d;
  logic [1:0]             good_q, good_d;
  logic                   per_bad_q, per_bad_d;

  logic       sync_lvl, edge_det, rise, fall;
  logic       cnt_sat, stuck_hit;
  logic [7:0] hi_meas;
  logic       hi_bad, lo_bad;
  logic       hi_check, lo_check, stuck_evt;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_lvl ^ hist_q;
  assign rise     = edge_det & sync_lvl;
  assign fall     = edge_det & ~sync_lvl;
  assign cnt_sat  = (cnt_q == CntMax);

`ifdef JTAG_AZ_MON_STUCK_EN
  assign stuck_hit = cnt_sat;
`else
  assign stuck_hit = 1'b0;
`endif

  assign hi_meas = (cnt_q > 14'd255) ? 8'hff : cnt_q[7:0];
  assign hi_bad  = abs_diff({7'b0, hi_meas}, {7'b0, NHIGH}) > {11'b0, TOL};
  assign lo_bad  = abs_diff({1'b0, cnt_q}, {1'b0, NLOW}) > {11'b0, TOL};

  always_comb begin
    state_d   = state_q;
    hi_check  = 1'b0;
    lo_check  = 1'b0;
    stuck_evt = 1'b0;
    if (!ARM) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     state_d = StWaitRise;
        StWaitRise: if (rise) state_d = StMeasHi;
        StMeasHi: begin
          if (fall) begin
            hi_check = 1'b1;
            state_d  = StMeasLo;
          end else if (stuck_hit) begin
            stuck_evt = 1'b1;
            state_d   = StWaitRise;
          end
        end
        StMeasLo: begin
          if (rise) begin
            lo_check = 1'b1;
            state_d  = StMeasHi;
          end else if (stuck_hit) begin
            stuck_evt = 1'b1;
            state_d   = StWaitRise;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle || !ARM) begin
      cnt_d = '0;
    end else if (edge_det) begin
      cnt_d = 14'd1;
    end else if (!cnt_sat) begin
      cnt_d = cnt_q + 14'd1;
    end
  end

  // Clear is applied first so a same-cycle check or period event still lands.
  always_comb begin
    meas_high_d  = hi_check ? hi_meas : meas_high_q;
    meas_low_d   = lo_check ? cnt_q : meas_low_q;
    meas_valid_d = lo_check;
    err_high_d   = (CLEAR ? 1'b0 : err_high_q) | (hi_check & hi_bad);
    err_low_d    = (CLEAR ? 1'b0 : err_low_q) | (lo_check & lo_bad);
    stuck_d      = (CLEAR ? 1'b0 : stuck_q) | stuck_evt;
    per_bad_d    = hi_check ? hi_bad : per_bad_q;

    period_d = CLEAR ? 16'd0 : period_q;
    if (lo_check && period_d != 16'hffff) begin
      period_d = period_d + 16'd1;
    end

    good_d = CLEAR ? 2'd0 : good_q;
    if (!ARM || stuck_evt) begin
      good_d = 2'd0;
    end else if (hi_check && hi_bad) begin
      good_d = 2'd0;
    end else if (lo_check) begin
      if (lo_bad || per_bad_q) begin
        good_d = 2'd0;
      end else if (good_d != 2'd2) begin
        good_d = good_d + 2'd1;
      end
    end
  end

  always_ff @(posedge TCK) begin
    if (!RESET) begin
      state_q      <= StIdle;
      sync_q       <= '0;
      hist_q       <= 1'b0;
      cnt_q        <= '0;
      meas_high_q  <= '0;
      meas_low_q   <= '0;
      meas_valid_q <= 1'b0;
      period_q     <= '0;
      err_high_q   <= 1'b0;
      err_low_q    <= 1'b0;
      stuck_q      <= 1'b0;
      good_q       <= '0;
      per_bad_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], PHI_AZ_IN};
      hist_q       <= sync_lvl;
      cnt_q        <= cnt_d;
      meas_high_q  <= meas_high_d;
      meas_low_q   <= meas_low_d;
      meas_valid_q <= meas_valid_d;
      period_q     <= period_d;
      err_high_q   <= err_high_d;
      err_low_q    <= err_low_d;
      stuck_q      <= stuck_d;
      good_q       <= good_d;
      per_bad_q    <= per_bad_d;
    end
  end

  assign MEAS_HIGH    = meas_high_q;
  assign MEAS_LOW     = meas_low_q;
  assign MEAS_VALID   = meas_valid_q;
  assign PERIOD_COUNT = period_q;
  assign ERR_HIGH     = err_high_q;
  assign ERR_LOW      = err_low_q;
  assign STUCK        = stuck_q;
  assign LOCKED       = (good_q == 2'd2);

endmodule

// File: tb/tb_jtag_az_monitor.sv
// Directed bench for jtag_az_monitor; PHI_AZ_IN driven TCK-synchronously, outputs sampled 1 ns after TCK.
module tb_jtag_az_monitor;

  logic        TCK = 1'b0;
  logic        RESET, PHI_AZ_IN, ARM, CLEAR;
  logic [7:0]  NHIGH;
  logic [13:0] NLOW;
  logic [3:0]  TOL;
  logic [7:0]  MEAS_HIGH;
  logic [13:0] MEAS_LOW;
  logic        MEAS_VALID;
  logic [15:0] PERIOD_COUNT;
  logic        ERR_HIGH, ERR_LOW, LOCKED, STUCK;

  int passed = 0;
  int checks = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int v_time[64];
  logic v_locked[64];
  int base;

  jtag_az_monitor #(.SYNC_STAGES(2)) dut (
    .TCK(TCK), .RESET(RESET), .PHI_AZ_IN(PHI_AZ_IN), .ARM(ARM), .CLEAR(CLEAR),
    .NHIGH(NHIGH), .NLOW(NLOW), .TOL(TOL),
    .MEAS_HIGH(MEAS_HIGH), .MEAS_LOW(MEAS_LOW), .MEAS_VALID(MEAS_VALID),
    .PERIOD_COUNT(PERIOD_COUNT), .ERR_HIGH(ERR_HIGH), .ERR_LOW(ERR_LOW),
    .LOCKED(LOCKED), .STUCK(STUCK)
  );

  always #5 TCK = ~TCK;

  always @(posedge TCK) cyc++;

  always @(negedge TCK) begin
    if (MEAS_VALID === 1'b1) begin
      if (valid_cnt < 64) begin
        v_time[valid_cnt]   = cyc;
        v_locked[valid_cnt] = LOCKED;
      end
      valid_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge TCK);
      #1;
    end
  endtask

  task automatic phase(input logic v, input int n);
    PHI_AZ_IN = v;
    tick(n);
  endtask

  task automatic test_reset;
    RESET = 1'b0; ARM = 1'b0; CLEAR = 1'b0; PHI_AZ_IN = 1'b0;
    NHIGH = 8'd4; NLOW = 14'd10; TOL = 4'd0;
    tick(2);
    checks++;
    if ({MEAS_HIGH, MEAS_LOW, PERIOD_COUNT} !== 38'd0)
      $display("FAIL reset_regs: got %0h exp 0", {MEAS_HIGH, MEAS_LOW, PERIOD_COUNT});
    else passed++;
    checks++;
    if ({MEAS_VALID, ERR_HIGH, ERR_LOW, LOCKED, STUCK} !== 5'd0)
      $display("FAIL reset_flags: got %b exp 00000", {MEAS_VALID, ERR_HIGH, ERR_LOW, LOCKED, STUCK});
    else passed++;
    RESET = 1'b1;
    tick(1);
  endtask

  task automatic test_clean;
    ARM = 1'b1;
    phase(1'b0, 4);
    base = valid_cnt;
    repeat (3) begin
      phase(1'b1, 4);
      phase(1'b0, 10);
    end
    phase(1'b1, 4);
    checks++;
    if (valid_cnt - base !== 3) $display("FAIL clean_valid_cnt: got %0d exp 3", valid_cnt - base);
    else passed++;
    checks++;
    if (MEAS_HIGH !== 8'd4) $display("FAIL clean_meas_high: got %0d exp 4", MEAS_HIGH);
    else passed++;
    checks++;
    if (MEAS_LOW !== 14'd10) $display("FAIL clean_meas_low: got %0d exp 10", MEAS_LOW);
    else passed++;
    checks++;
    if (PERIOD_COUNT !== 16'd3) $display("FAIL clean_period_count: got %0d exp 3", PERIOD_COUNT);
    else passed++;
    checks++;
    if ({ERR_HIGH, ERR_LOW} !== 2'b00) $display("FAIL clean_errs: got %b exp 00", {ERR_HIGH, ERR_LOW});
    else passed++;
    checks++;
    if (LOCKED !== 1'b1) $display("FAIL clean_locked: got %b exp 1", LOCKED);
    else passed++;
    checks++;
    if (MEAS_VALID !== 1'b0) $display("FAIL clean_valid_pulse: got %b exp 0", MEAS_VALID);
    else passed++;
    checks++;
    if (v_locked[base] !== 1'b0 || v_locked[base+1] !== 1'b1)
      $display("FAIL clean_lock_seq: got %b%b exp 01", v_locked[base], v_locked[base+1]);
    else passed++;
    checks++;
    if (v_time[base+2] - v_time[base+1] !== 14)
      $display("FAIL clean_valid_spacing: got %0d exp 14", v_time[base+2] - v_time[base+1]);
    else passed++;
  endtask

  task automatic test_high_tol;
    ARM = 1'b0;
    phase(1'b0, 4);
    CLEAR = 1'b1; tick(1); CLEAR = 1'b0;
    NHIGH = 8'd4; TOL = 4'd1; ARM = 1'b1;
    phase(1'b0, 3);
    phase(1'b1, 6);
    phase(1'b0, 4);
    checks++;
    if (MEAS_HIGH !== 8'd6) $display("FAIL tol1_meas_high: got %0d exp 6", MEAS_HIGH);
    else passed++;
    checks++;
    if (ERR_HIGH !== 1'b1) $display("FAIL tol1_err_high: got %b exp 1", ERR_HIGH);
    else passed++;
    checks++;
    if (LOCKED !== 1'b0) $display("FAIL tol1_locked: got %b exp 0", LOCKED);
    else passed++;
    TOL = 4'd2;
    CLEAR = 1'b1; phase(1'b0, 1); CLEAR = 1'b0;
    checks++;
    if (ERR_HIGH !== 1'b0) $display("FAIL tol2_cleared: got %b exp 0", ERR_HIGH);
    else passed++;
    phase(1'b0, 5);
    phase(1'b1, 6);
    phase(1'b0, 4);
    checks++;
    if (ERR_HIGH !== 1'b0) $display("FAIL tol2_err_high: got %b exp 0", ERR_HIGH);
    else passed++;
    checks++;
    if (MEAS_HIGH !== 8'd6 || MEAS_LOW !== 14'd10 || ERR_LOW !== 1'b0)
      $display("FAIL tol2_meas: got %0d/%0d/%b exp 6/10/0", MEAS_HIGH, MEAS_LOW, ERR_LOW);
    else passed++;
  endtask

  task automatic test_clear;
    ARM = 1'b0;
    tick(2);
    CLEAR = 1'b1; tick(1); CLEAR = 1'b0;
    NHIGH = 8'd4; NLOW = 14'd10; TOL = 4'd0; ARM = 1'b1;
    phase(1'b0, 3);
    phase(1'b1, 4); phase(1'b0, 10);
    phase(1'b1, 4); phase(1'b0, 12);
    repeat (3) begin
      phase(1'b1, 4); phase(1'b0, 10);
    end
    phase(1'b1, 3);
    checks++;
    if (PERIOD_COUNT !== 16'd5) $display("FAIL clear_pre_count: got %0d exp 5", PERIOD_COUNT);
    else passed++;
    checks++;
    if (ERR_LOW !== 1'b1 || ERR_HIGH !== 1'b0)
      $display("FAIL clear_pre_errs: got %b%b exp 01", ERR_HIGH, ERR_LOW);
    else passed++;
    CLEAR = 1'b1; phase(1'b1, 1); CLEAR = 1'b0;
    checks++;
    if (PERIOD_COUNT !== 16'd0) $display("FAIL clear_count: got %0d exp 0", PERIOD_COUNT);
    else passed++;
    checks++;
    if (ERR_LOW !== 1'b0) $display("FAIL clear_err_low: got %b exp 0", ERR_LOW);
    else passed++;
    // CLEAR lands on the same edge as the bad low-phase check.
    phase(1'b0, 12);
    phase(1'b1, 2);
    CLEAR = 1'b1; phase(1'b1, 1); CLEAR = 1'b0;
    checks++;
    if (ERR_LOW !== 1'b1) $display("FAIL clear_coincident_err_low: got %b exp 1", ERR_LOW);
    else passed++;
    checks++;
    if (MEAS_LOW !== 14'd12) $display("FAIL clear_coincident_meas_low: got %0d exp 12", MEAS_LOW);
    else passed++;
  endtask

  task automatic test_arm_drop;
    phase(1'b1, 1);
    CLEAR = 1'b1; phase(1'b0, 1); CLEAR = 1'b0;
    phase(1'b0, 9);
    phase(1'b1, 4); phase(1'b0, 10);
    phase(1'b1, 4);
    checks++;
    if (LOCKED !== 1'b1 || PERIOD_COUNT !== 16'd2)
      $display("FAIL arm_pre_lock: got %b/%0d exp 1/2", LOCKED, PERIOD_COUNT);
    else passed++;
    phase(1'b0, 5);
    ARM = 1'b0;
    tick(2);
    checks++;
    if (LOCKED !== 1'b0) $display("FAIL arm_drop_locked: got %b exp 0", LOCKED);
    else passed++;
    checks++;
    if (MEAS_HIGH !== 8'd4 || MEAS_LOW !== 14'd10 || PERIOD_COUNT !== 16'd2)
      $display("FAIL arm_drop_hold: got %0d/%0d/%0d exp 4/10/2", MEAS_HIGH, MEAS_LOW, PERIOD_COUNT);
    else passed++;
    base = valid_cnt;
    phase(1'b1, 5); phase(1'b0, 5);
    checks++;
    if (valid_cnt !== base || PERIOD_COUNT !== 16'd2 || MEAS_LOW !== 14'd10)
      $display("FAIL arm_idle_ignore: got %0d/%0d/%0d exp 0/2/10",
               valid_cnt - base, PERIOD_COUNT, MEAS_LOW);
    else passed++;
  endtask

  task automatic test_reset_mid;
    ARM = 1'b1;
    phase(1'b0, 3);
    phase(1'b1, 4);
    phase(1'b0, 5);
    RESET = 1'b0;
    tick(1);
    checks++;
    if ({MEAS_HIGH, MEAS_LOW, PERIOD_COUNT} !== 38'd0)
      $display("FAIL rstmid_regs: got %0h exp 0", {MEAS_HIGH, MEAS_LOW, PERIOD_COUNT});
    else passed++;
    checks++;
    if ({MEAS_VALID, ERR_HIGH, ERR_LOW, LOCKED, STUCK} !== 5'd0)
      $display("FAIL rstmid_flags: got %b exp 00000", {MEAS_VALID, ERR_HIGH, ERR_LOW, LOCKED, STUCK});
    else passed++;
    RESET = 1'b1;
    base = valid_cnt;
    phase(1'b0, 5);
    phase(1'b1, 4);
    checks++;
    if (valid_cnt !== base || PERIOD_COUNT !== 16'd0)
      $display("FAIL rstmid_discard: got %0d/%0d exp 0/0", valid_cnt - base, PERIOD_COUNT);
    else passed++;
    phase(1'b0, 10);
    phase(1'b1, 4);
    checks++;
    if (PERIOD_COUNT !== 16'd1 || MEAS_HIGH !== 8'd4 || MEAS_LOW !== 14'd10)
      $display("FAIL rstmid_first_period: got %0d/%0d/%0d exp 1/4/10",
               PERIOD_COUNT, MEAS_HIGH, MEAS_LOW);
    else passed++;
  endtask

  task automatic test_stuck;
    base = valid_cnt;
    phase(1'b1, 17000);
    phase(1'b0, 4);
`ifdef JTAG_AZ_MON_STUCK_EN
    checks++;
    if (STUCK !== 1'b1) $display("FAIL stuck_flag: got %b exp 1", STUCK);
    else passed++;
    checks++;
    if (MEAS_HIGH !== 8'd4 || ERR_HIGH !== 1'b0)
      $display("FAIL stuck_no_meas: got %0d/%b exp 4/0", MEAS_HIGH, ERR_HIGH);
    else passed++;
`else
    checks++;
    if (STUCK !== 1'b0) $display("FAIL stuck_flag: got %b exp 0", STUCK);
    else passed++;
    checks++;
    if (MEAS_HIGH !== 8'd255 || ERR_HIGH !== 1'b1)
      $display("FAIL stuck_sat_meas: got %0d/%b exp 255/1", MEAS_HIGH, ERR_HIGH);
    else passed++;
`endif
    phase(1'b0, 6);
    phase(1'b1, 4);
`ifdef JTAG_AZ_MON_STUCK_EN
    checks++;
    if (valid_cnt - base !== 0 || PERIOD_COUNT !== 16'd1)
      $display("FAIL stuck_wait_rise: got %0d/%0d exp 0/1", valid_cnt - base, PERIOD_COUNT);
    else passed++;
`else
    checks++;
    if (valid_cnt - base !== 1 || PERIOD_COUNT !== 16'd2 || MEAS_LOW !== 14'd10)
      $display("FAIL stuck_next_low: got %0d/%0d/%0d exp 1/2/10",
               valid_cnt - base, PERIOD_COUNT, MEAS_LOW);
    else passed++;
`endif
    checks++;
    if (LOCKED !== 1'b0) $display("FAIL stuck_locked: got %b exp 0", LOCKED);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_high_tol();
    test_clear();
    test_arm_drop();
    test_reset_mid();
    test_stuck();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jtag_az_monitor.md
# jtag_az_monitor

Autozeroing waveform monitor: the receiving end of the Torino-only PHI_AZ PWM generator in the JTAG/EOC domain. Samples the (delayed, possibly asynchronous) PHI_AZ level on TCK, measures every high and low phase width in TCK cycles, and checks them against the programmed NHIGH/NLOW with a programmable tolerance. Provides per-period measurements, period count, sticky error flags and a lock indicator for JTAG readback and for the bench.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on PHI_AZ_IN (legal 2..3)

Ports:
- TCK  input  1  monitor clock, rising-edge
- RESET  input  1  synchronous, active-low reset
- PHI_AZ_IN  input  1  AZ waveform under test, treated as asynchronous
- ARM  input  1  level; 1 = monitor running, 0 = idle
- CLEAR  input  1  single-cycle pulse; clears flags and period count
- NHIGH  input  8  expected high width, TCK cycles
- NLOW  input  14  expected low width, TCK cycles
- TOL  input  4  allowed absolute deviation, cycles
- MEAS_HIGH  output  8  last measured high width
- MEAS_LOW  output  14  last measured low width
- MEAS_VALID  output  1  one-cycle pulse: full period measured
- PERIOD_COUNT  output  16  completed periods since CLEAR, saturating
- ERR_HIGH  output  1  sticky: high width out of tolerance
- ERR_LOW  output  1  sticky: low width out of tolerance
- LOCKED  output  1  two consecutive in-tolerance periods seen
- STUCK  output  1  sticky: phase counter saturated (see Configuration)

## Operation
- Synchronizer: SYNC_STAGES flops then one history flop; sync = last stage, edge = sync != history.
- Phase counter (14 bit): loads 1 on edge cycle, else increments, saturating at all-ones of 14 bits; high width read as min(count,255).
- FSM states: IDLE, WAIT_RISE, MEAS_HI, MEAS_LO.
  - IDLE: ARM=1 -> WAIT_RISE. Counter held 0.
  - WAIT_RISE: discards the partial first phase; rising edge -> MEAS_HI.
  - MEAS_HI: falling edge -> latch MEAS_HIGH = counter (saturated to 8 bit), evaluate high check, -> MEAS_LO.
  - MEAS_LO: rising edge -> latch MEAS_LOW, evaluate low check, pulse MEAS_VALID, PERIOD_COUNT+1 (hold at 0xFFFF), -> MEAS_HI.
  - ARM=0 in any state -> IDLE next cycle; measurement registers, flags, PERIOD_COUNT retained; LOCKED cleared.
- Check: 15-bit unsigned |meas - N| > TOL sets the ERR flag. NHIGH/NLOW = 0 is legal and compares literally (every measurement ≥ 1).
- LOCKED: 2-bit good-period counter; increments on MEAS_VALID with no error in that period, LOCKED=1 at 2; any check failure clears counter and LOCKED.
- CLEAR: zeroes ERR_HIGH, ERR_LOW, STUCK, PERIOD_COUNT, LOCKED counter. CLEAR and a same-cycle error event: error wins (flag set). CLEAR does not change FSM state.
- Configuration inputs are quasi-static; changes mid-period apply to the next check evaluated.

## Timing
- Reset (RESET=0 at TCK edge): all outputs 0, FSM IDLE, synchronizer and counter 0. Reset mid-measurement aborts with no MEAS_VALID.
- Edge detection latency: SYNC_STAGES+1 TCK edges after PHI_AZ_IN transition is first sampled.
- MEAS_HIGH/MEAS_LOW/ERR_*/MEAS_VALID update on the edge after the edge-detect cycle (registered).
- Measured width equals the number of TCK cycles sync held the level; a clean TCK-synchronous input gives exactly NHIGH/NLOW, async input ±1.
- Pulses shorter than one TCK may be missed; no glitch filtering.

## Configuration
- JTAG_AZ_MON_STUCK_EN defined: STUCK sets when the phase counter saturates in MEAS_HI or MEAS_LO; FSM returns to WAIT_RISE, LOCKED cleared, no MEAS_VALID for that period.
- Not defined: STUCK tied 0; counter saturates silently and FSM stays in its state until the next edge.

## Test plan
- Clean waveform NHIGH=4, NLOW=10, TOL=0, ARM=1 -> from 2nd period on MEAS_HIGH=4, MEAS_LOW=10, MEAS_VALID every 14 cycles, LOCKED after 2 periods, no errors.
- High phase 6 with NHIGH=4, TOL=1 -> ERR_HIGH set at falling-edge check, LOCKED 0; same with TOL=2 -> no error.
- Reset asserted mid MEAS_LO -> next cycle all outputs 0, no MEAS_VALID; after release and ARM, first period discarded.
- CLEAR pulse after 5 periods with ERR_LOW set -> PERIOD_COUNT=0, ERR_LOW=0; CLEAR coincident with bad low check -> ERR_LOW=1.
- PHI_AZ_IN held high 17000 cycles -> MEAS_HIGH=255 at next falling edge; with JTAG_AZ_MON_STUCK_EN STUCK=1 and FSM in WAIT_RISE.
- ARM dropped mid-period -> IDLE, LOCKED 0, MEAS_* and PERIOD_COUNT unchanged.
